mips_dmem_subsys: RTL and testbench
===================================

MIPS_DMEM_SUBSYS -- requirements
Module: mips_dmem_subsys

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, data RAM depth in 32-bit words; power of two, 16..4096.
REQ-002 Parameter WAIT_STATES, default 1, extra access cycles inserted per transaction, 0..7.
REQ-003 Parameter NUM_IO, default 2, number of memory-mapped 16-bit output registers, 1..8.
REQ-004 Parameter IO_BASE, default 32'hFFFF_0000, base byte address of the IO window.
REQ-005 Clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Req  in  1  access request; held high by the requester until Ready.
REQ-008 We  in  1  1 = write, 0 = read.
REQ-009 Addr  in  32  byte address.
REQ-010 WData  in  32  write data.
REQ-011 ByteEn  in  4  byte-lane write enables; bit i covers WData[8i+7:8i].
REQ-012 RData  out  32  read data; valid only while Ready=1.
REQ-013 Ready  out  1  one-cycle pulse that completes a transaction.
REQ-014 Stall  out  1  processor freeze; equals Req & ~Ready.
REQ-015 Err  out  1  decode or alignment error; valid only while Ready=1.
REQ-016 IoOut  out  16*NUM_IO  IO register contents; register k occupies bits [16k+15:16k].
REQ-017 IoWrStrobe  out  NUM_IO  one-cycle pulse on register k when it is written.

Function
REQ-018 The block SHALL use FSM states IDLE, WAIT and RESP.
REQ-019 IDLE: on a rising edge with Req=1, latch Addr/WData/We/ByteEn, load the wait counter with WAIT_STATES and go to WAIT.
REQ-020 WAIT: decrement the counter each cycle; at the edge where the counter is 0, perform the access and go to RESP.
REQ-021 RESP: drive Ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-022 Latency: Req sampled at edge N gives Ready high in the cycle after edge N+1+WAIT_STATES.
REQ-023 Throughput: at most one transaction per WAIT_STATES+3 cycles; a request is accepted only in IDLE.
REQ-024 Deasserting Req after acceptance SHALL NOT cancel the latched transaction.
REQ-025 Changes on Addr/WData/We/ByteEn after acceptance SHALL be ignored.
REQ-026 RAM region: Addr < DEPTH_WORDS*4 with Addr[1:0]=0; the word index is Addr[log2(DEPTH_WORDS)+1:2].
REQ-027 RAM write: update only the lanes enabled in ByteEn; ByteEn=0 completes normally with no change.
REQ-028 RAM read: RData returns the full word; ByteEn is ignored on reads.
REQ-029 IO region: Addr[31:16]=IO_BASE[31:16], Addr[15:5]=0, Addr[1:0]=0 and k=Addr[4:2] < NUM_IO.
REQ-030 IO write: honour ByteEn[1:0] on WData[15:0] into register k; pulse IoWrStrobe[k] in the Ready cycle.
REQ-031 IO read: return register k zero-extended to 32 bits.
REQ-032 Any other address, or Addr[1:0]≠0, SHALL return Err=1 and RData=0 with Ready, with no state change.
REQ-033 Outside the Ready cycle, RData, Err and IoWrStrobe SHALL be 0.

Reset
REQ-034 Reset SHALL force IDLE and set Ready, Err, RData, IoWrStrobe and every IoOut register to 0.
REQ-035 Reset in WAIT or RESP SHALL abandon the transaction: no write, no Ready pulse.
REQ-036 RAM contents SHALL be unaffected by Reset.
REQ-037 If Reset and Req are high on the same edge, Reset wins and the request is not accepted.

Structure
REQ-038 Package mips_mem_pkg SHALL hold the FSM state type, the region decode type (RAM/IO/ERR) and the IO_BASE default.
REQ-039 The RAM array with byte-lane write and registered read SHALL be a sub-module mips_dmem_ram.
REQ-040 The FSM, address decode and IO registers SHALL reside in mips_dmem_subsys.

Verification
REQ-041 WAIT_STATES=1: write 32'hDEADBEEF to 0x10 with ByteEn=4'hF, then read 0x10 -> RData=32'hDEADBEEF; Ready in the 3rd cycle after acceptance each time.
REQ-042 Write 32'h000000AA to 0x20 with ByteEn=4'b0001 over existing 32'h11223344 -> read returns 32'h112233AA.
REQ-043 Write 32'h1234_5678 to 0xFFFF0004 with NUM_IO=2 -> IoOut[31:16]=16'h5678 and IoWrStrobe=2'b10 for one cycle; read back returns 32'h00005678.
REQ-044 Access 0xFFFF0008 with NUM_IO=2, to 0x0000_0400 with DEPTH_WORDS=256, and to 0x13 -> Err=1, RData=0, no memory or IO change.
REQ-045 Reset asserted in WAIT during a write of 32'hCAFEF00D to 0x40 -> no Ready pulse, FSM in IDLE, later read of 0x40 returns the old value.
REQ-046 Req held continuously with WAIT_STATES=0 -> Ready pulses every 3rd cycle and Stall is low only in Ready cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and address decode for the MIPS data-memory subsystem.
// Holds the FSM state encoding, the region classification and the IO window default.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_IO  = 2'd1,
        REG_ERR = 2'd2
    } region_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

    // Misaligned addresses are errors regardless of region; RAM is checked before IO.
    function automatic region_t decode_region(
        input logic [31:0] addr,
        input int          aw,
        input int          num_io,
        input logic [15:0] io_page
    );
        region_t r;
        r = REG_ERR;
        if (addr[1:0] != 2'd0) begin
            r = REG_ERR;
        end else if ((addr >> (aw + 2)) == 32'd0) begin
            r = REG_RAM;
        end else if ((addr[31:16] == io_page) && (addr[15:5] == 11'd0) &&
                     (int'({29'd0, addr[4:2]}) < num_io)) begin
            r = REG_IO;
        end else begin
            r = REG_ERR;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_dmem_ram.sv
// Word-organised data RAM with per-byte write lanes and a registered read port.
// Contents carry no reset so they survive a subsystem reset.
module mips_dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] word_addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    byte_en,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write and registered full-word read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && byte_en[i]) begin
                mem[word_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[word_addr];
        end
    end

endmodule

// File: rtl/mips_dmem_subsys.sv
// Request/ready data-memory subsystem: FSM with programmable wait states,
// region decode, memory-mapped 16-bit output registers and the data RAM.
module mips_dmem_subsys
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1,
    parameter int          NUM_IO      = 2,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  We,
    input  logic [31:0]           Addr,
    input  logic [31:0]           WData,
    input  logic [3:0]            ByteEn,
    output logic [31:0]           RData,
    output logic                  Ready,
    output logic                  Stall,
    output logic                  Err,
    output logic [16*NUM_IO-1:0]  IoOut,
    output logic [NUM_IO-1:0]     IoWrStrobe
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t                  state, state_nxt;
    logic [2:0]              cnt;
    logic [31:0]             addr_l, wdata_l;
    logic                    we_l;
    logic [3:0]              be_l;
    region_t                 region;
    logic                    access, resp;
    logic [2:0]              io_idx;
    logic [15:0]             io_sel;
    logic [NUM_IO-1:0][15:0] io_regs;
    logic [NUM_IO-1:0]       strobe_r;
    logic                    err_r, resp_ram_r;
    logic [31:0]             io_rdata_r, ram_rdata;

    assign region = decode_region(addr_l, AW, NUM_IO, IO_BASE[31:16]);
    assign access = (state == ST_WAIT) && (cnt == 3'd0) && !Reset;
    assign io_idx = addr_l[4:2];

    // Next-state logic for the IDLE/WAIT/RESP handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (Req) state_nxt = ST_WAIT; else state_nxt = ST_IDLE;
            ST_WAIT: if (cnt == 3'd0) state_nxt = ST_RESP; else state_nxt = ST_WAIT;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Selected IO register for reads.
    always_comb begin
        io_sel = 16'd0;
        for (int k = 0; k < NUM_IO; k++) begin
            io_sel = io_sel | ((io_idx == 3'(k)) ? io_regs[k] : 16'd0);
        end
    end

    // Request latch, wait counter, IO registers and one-cycle response flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt        <= 3'd0;
            addr_l     <= 32'd0;
            wdata_l    <= 32'd0;
            we_l       <= 1'b0;
            be_l       <= 4'd0;
            io_regs    <= '0;
            strobe_r   <= '0;
            err_r      <= 1'b0;
            resp_ram_r <= 1'b0;
            io_rdata_r <= 32'd0;
        end else begin
            strobe_r   <= '0;
            err_r      <= 1'b0;
            resp_ram_r <= 1'b0;
            io_rdata_r <= 32'd0;
            if (state == ST_IDLE && Req) begin
                addr_l  <= Addr;
                wdata_l <= WData;
                we_l    <= We;
                be_l    <= ByteEn;
                cnt     <= 3'(WAIT_STATES);
            end
            if (state == ST_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (access) begin
                case (region)
                    REG_RAM: resp_ram_r <= !we_l;
                    REG_IO: begin
                        if (we_l) begin
                            for (int k = 0; k < NUM_IO; k++) begin
                                if (io_idx == 3'(k)) begin
                                    if (be_l[0]) io_regs[k][7:0]  <= wdata_l[7:0];
                                    if (be_l[1]) io_regs[k][15:8] <= wdata_l[15:8];
                                    strobe_r[k] <= 1'b1;
                                end
                            end
                        end else begin
                            io_rdata_r <= {16'd0, io_sel};
                        end
                    end
                    REG_ERR: err_r <= 1'b1;
                    default: err_r <= 1'b1;
                endcase
            end
        end
    end

    mips_dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk       (Clk),
        .wr_en     (access && (region == REG_RAM) && we_l),
        .rd_en     (access && (region == REG_RAM) && !we_l),
        .word_addr (addr_l[AW+1:2]),
        .wdata     (wdata_l),
        .byte_en   (be_l),
        .rdata     (ram_rdata)
    );

    // A reset landing on the response cycle suppresses the Ready pulse.
    assign resp       = (state == ST_RESP) && !Reset;
    assign Ready      = resp;
    assign RData      = resp ? (resp_ram_r ? ram_rdata : io_rdata_r) : 32'd0;
    assign Err        = resp & err_r;
    assign IoWrStrobe = resp ? strobe_r : {NUM_IO{1'b0}};
    assign IoOut      = io_regs;
    assign Stall      = Req & ~Ready;

endmodule

// File: tb/tb_mips_dmem_subsys.sv
// Directed self-checking bench for mips_dmem_subsys (WAIT_STATES=1 main
// instance, WAIT_STATES=0 instance for continuous-request throughput).
module tb_mips_dmem_subsys;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req, We;
    logic [31:0] Addr, WData, RData;
    logic [3:0]  ByteEn;
    logic        Ready, Stall, Err;
    logic [31:0] IoOut;
    logic [1:0]  IoWrStrobe;

    logic        req0, we0, ready0, stall0, err0;
    logic [31:0] addr0, wdata0, rdata0, ioout0;
    logic [3:0]  be0;
    logic [1:0]  strb0;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd, io, rd_a;
    logic        er, er_a;
    logic [1:0]  st, st_a;
    int          lat;

    always #5 Clk = ~Clk;

    mips_dmem_subsys #(.DEPTH_WORDS(256), .WAIT_STATES(1), .NUM_IO(2)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Addr(Addr), .WData(WData),
        .ByteEn(ByteEn), .RData(RData), .Ready(Ready), .Stall(Stall), .Err(Err),
        .IoOut(IoOut), .IoWrStrobe(IoWrStrobe)
    );

    mips_dmem_subsys #(.DEPTH_WORDS(256), .WAIT_STATES(0), .NUM_IO(2)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req(req0), .We(we0), .Addr(addr0), .WData(wdata0),
        .ByteEn(be0), .RData(rdata0), .Ready(ready0), .Stall(stall0), .Err(err0),
        .IoOut(ioout0), .IoWrStrobe(strb0)
    );

    // One transaction; inputs are scrambled after acceptance. lat=99 on timeout.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic drop);
        logic got;
        @(negedge Clk);
        Req = 1'b1; We = w; Addr = a; WData = d; ByteEn = be;
        lat = 0; got = 1'b0;
        rd = 32'hX; er = 1'bX; st = 2'bX; io = 32'hX;
        while (!got && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
            if (lat == 1) begin
                Addr = 32'h13; WData = ~d; We = ~w; ByteEn = ~be;
                if (drop) Req = 1'b0;
            end
            if (Ready) begin
                got = 1'b1;
                rd = RData; er = Err; st = IoWrStrobe; io = IoOut;
            end
        end
        Req = 1'b0;
        if (!got) lat = 99;
        @(posedge Clk); #1;
        rd_a = RData; er_a = Err; st_a = IoWrStrobe;
    endtask

    task automatic test_reset;
        @(negedge Clk);
        total++; if (Ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", Ready); end
        total++; if (Err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", Err); end
        total++; if (RData !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", RData); end
        total++; if (IoOut !== 32'd0) begin bad++; $display("FAIL reset_ioout got=%h exp=0", IoOut); end
        total++; if (IoWrStrobe !== 2'd0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", IoWrStrobe); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", Stall); end
    endtask

    task automatic test_ram_word;
        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", er); end
        access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_word got=%h exp=deadbeef", rd); end
        total++; if (rd_a !== 32'd0) begin bad++; $display("FAIL rdata_after got=%h exp=0", rd_a); end
    endtask

    task automatic test_byte_lane;
        access(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
        access(1'b1, 32'h20, 32'h000000AA, 4'b0001, 1'b1);
        access(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        total++; if (rd !== 32'h112233AA) begin bad++; $display("FAIL byte_lane got=%h exp=112233aa", rd); end
        access(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0);
        total++; if (lat !== 3 || er !== 1'b0) begin bad++; $display("FAIL be_zero_done got=%0d/%b exp=3/0", lat, er); end
        access(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        total++; if (rd !== 32'h112233AA) begin bad++; $display("FAIL be_zero_data got=%h exp=112233aa", rd); end
    endtask

    task automatic test_io;
        access(1'b1, 32'hFFFF0004, 32'h12345678, 4'hF, 1'b0);
        total++; if (st !== 2'b10) begin bad++; $display("FAIL io_strobe got=%b exp=10", st); end
        total++; if (io !== 32'h56780000) begin bad++; $display("FAIL io_out got=%h exp=56780000", io); end
        total++; if (st_a !== 2'b00) begin bad++; $display("FAIL io_strobe_after got=%b exp=00", st_a); end
        access(1'b0, 32'hFFFF0004, 32'h0, 4'h0, 1'b0);
        total++; if (rd !== 32'h00005678) begin bad++; $display("FAIL io_read got=%h exp=00005678", rd); end
        access(1'b1, 32'hFFFF0000, 32'hAAAA99CD, 4'b0001, 1'b0);
        total++; if (IoOut !== 32'h567800CD) begin bad++; $display("FAIL io_lane got=%h exp=567800cd", IoOut); end
        total++; if (st !== 2'b01) begin bad++; $display("FAIL io_strobe0 got=%b exp=01", st); end
    endtask

    task automatic test_errors;
        logic [31:0] bad_addr [3];
        bad_addr[0] = 32'hFFFF0008; bad_addr[1] = 32'h00000400; bad_addr[2] = 32'h00000013;
        access(1'b1, 32'h0, 32'h55555555, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            access(1'b1, bad_addr[i], 32'hFFFFFFFF, 4'hF, 1'b0);
            total++; if (er !== 1'b1 || rd !== 32'd0 || st !== 2'b00) begin
                bad++; $display("FAIL err_wr[%0d] got=%b/%h/%b exp=1/0/00", i, er, rd, st); end
            total++; if (er_a !== 1'b0) begin bad++; $display("FAIL err_after[%0d] got=%b exp=0", i, er_a); end
            access(1'b0, bad_addr[i], 32'h0, 4'h0, 1'b0);
            total++; if (er !== 1'b1 || rd !== 32'd0) begin
                bad++; $display("FAIL err_rd[%0d] got=%b/%h exp=1/0", i, er, rd); end
        end
        total++; if (IoOut !== 32'h567800CD) begin bad++; $display("FAIL err_io_kept got=%h exp=567800cd", IoOut); end
        access(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        total++; if (rd !== 32'h55555555) begin bad++; $display("FAIL err_ram0_kept got=%h exp=55555555", rd); end
        access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL err_ram10_kept got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_abort;
        int seen;
        access(1'b1, 32'h40, 32'h0BADF00D, 4'hF, 1'b0);
        @(negedge Clk);
        Req = 1'b1; We = 1'b1; Addr = 32'h40; WData = 32'hCAFEF00D; ByteEn = 4'hF;
        @(posedge Clk); #1;
        Reset = 1'b1; Req = 1'b0;
        seen = 0;
        for (int i = 0; i < 2; i++) begin @(posedge Clk); #1; if (Ready) seen++; end
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge Clk); #1; if (Ready) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_ready got=%0d exp=0", seen); end
        total++; if (IoOut !== 32'd0) begin bad++; $display("FAIL abort_io_cleared got=%h exp=0", IoOut); end
        @(negedge Clk);
        Reset = 1'b1; Req = 1'b1; We = 1'b1; Addr = 32'h40; WData = 32'h0; ByteEn = 4'hF;
        @(negedge Clk);
        Reset = 1'b0; Req = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin @(posedge Clk); #1; if (Ready) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL reset_beats_req got=%0d exp=0", seen); end
        access(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        total++; if (lat !== 3) begin bad++; $display("FAIL abort_idle_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL abort_old_value got=%h exp=0badf00d", rd); end
    endtask

    task automatic test_back_to_back;
        logic exp_ready;
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h0; be0 = 4'h0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clk); #1;
            exp_ready = ((i % 3) == 2);
            total++; if (ready0 !== exp_ready) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, ready0, exp_ready); end
            total++; if (stall0 !== !exp_ready) begin bad++; $display("FAIL b2b_stall[%0d] got=%b exp=%b", i, stall0, !exp_ready); end
        end
        req0 = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Req = 1'b0; We = 1'b0; Addr = 32'd0; WData = 32'd0; ByteEn = 4'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0; be0 = 4'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        test_reset;
        test_ram_word;
        test_byte_lane;
        test_io;
        test_errors;
        test_abort;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
